// File: rtl/transient_pkg.sv
// rtl/transient_pkg.sv - shared types and constants for the transient burst sequencer
//
// Contents:
//   tb_state_t     sequencer state encoding
//   CNT_W_DEFAULT  default width of configuration fields and counters
//   ZERO_COUNT     count value meaning "skip this phase"
package transient_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_ON    = 3'd2,
        ST_OFF   = 3'd3,
        ST_DONE  = 3'd4
    } tb_state_t;

    localparam int CNT_W_DEFAULT = 16;
    localparam int ZERO_COUNT    = 0;

endpackage

// File: rtl/tn_cycle_counter.sv
// rtl/tn_cycle_counter.sv - load/decrement down-counter with a zero flag
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val this cycle (wins over dec)
//   load_val    value to load
//   dec         decrement by one; saturates at zero, never wraps
//   zero        count is zero
module tn_cycle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/transient_burst_ctrl.sv
// rtl/transient_burst_ctrl.sv - delay / burst / gap sequencer driving the transient network trigger
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        run request, honoured only in IDLE
//   abort        return to IDLE next cycle; beats start in IDLE
//   cfg_delay    cycles from start acceptance to first trigger
//   cfg_on       trigger-high cycles per burst
//   cfg_off      idle cycles between bursts
//   cfg_bursts   bursts per run
//   trigger      registered clock enable for the transient network
//   busy         high in DELAY, ON, OFF
//   done         one-cycle pulse on normal completion
//   burst_mark   one-cycle pulse on the first ON cycle of every burst
//   burst_idx    0-based index of the current or last burst
module transient_burst_ctrl
    import transient_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_on,
    input  logic [CNT_W-1:0] cfg_off,
    input  logic [CNT_W-1:0] cfg_bursts,
    output logic             trigger,
    output logic             busy,
    output logic             done,
    output logic             burst_mark,
    output logic [CNT_W-1:0] burst_idx
);

    localparam logic [CNT_W-1:0] ZERO = CNT_W'(ZERO_COUNT);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    tb_state_t        state, state_nx;

    // cfg_delay and cfg_bursts are captured directly by the counters at
    // acceptance; only the per-burst reload values need their own latches.
    logic [CNT_W-1:0] on_q, off_q;

    logic             ph_load, ph_dec, ph_zero;
    logic [CNT_W-1:0] ph_val;
    logic             bu_load, bu_dec, bu_zero;
    logic [CNT_W-1:0] bu_val;

    logic             accept;
    logic             new_burst;
    logic             idx_inc;

    logic             trigger_d, busy_d, done_d, mark_d;
    logic [CNT_W-1:0] idx_d;

    // Counters are loaded with (count - 1) on phase entry and the phase ends
    // in the cycle the counter reads zero, so a phase of C cycles needs no
    // C+1 headroom and the all-ones maximum works without wrapping.
    tn_cycle_counter #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ph_load),
        .load_val (ph_val),
        .dec      (ph_dec),
        .zero     (ph_zero)
    );

    tn_cycle_counter #(.CNT_W(CNT_W)) u_burst_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bu_load),
        .load_val (bu_val),
        .dec      (bu_dec),
        .zero     (bu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ph_load   = 1'b0;
        ph_val    = ZERO;
        ph_dec    = 1'b0;
        bu_load   = 1'b0;
        bu_val    = ZERO;
        bu_dec    = 1'b0;
        accept    = 1'b0;
        new_burst = 1'b0;
        idx_inc   = 1'b0;

        if ((state != ST_IDLE) && abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        accept = 1'b1;
                        if ((cfg_on == ZERO) || (cfg_bursts == ZERO)) begin
                            state_nx = ST_DONE;
                        end else begin
                            bu_load = 1'b1;
                            bu_val  = cfg_bursts - ONE;
                            ph_load = 1'b1;
                            if (cfg_delay != ZERO) begin
                                state_nx = ST_DELAY;
                                ph_val   = cfg_delay - ONE;
                            end else begin
                                state_nx  = ST_ON;
                                ph_val    = cfg_on - ONE;
                                new_burst = 1'b1;
                            end
                        end
                    end
                end
                ST_DELAY: begin
                    if (ph_zero) begin
                        state_nx  = ST_ON;
                        ph_load   = 1'b1;
                        ph_val    = on_q - ONE;
                        new_burst = 1'b1;
                    end else begin
                        ph_dec = 1'b1;
                    end
                end
                ST_ON: begin
                    if (!ph_zero) begin
                        ph_dec = 1'b1;
                    end else if (bu_zero) begin
                        state_nx = ST_DONE;
                    end else begin
                        bu_dec  = 1'b1;
                        ph_load = 1'b1;
                        if (off_q != ZERO) begin
                            state_nx = ST_OFF;
                            ph_val   = off_q - ONE;
                        end else begin
                            // back-to-back bursts: trigger stays high
                            state_nx  = ST_ON;
                            ph_val    = on_q - ONE;
                            new_burst = 1'b1;
                            idx_inc   = 1'b1;
                        end
                    end
                end
                ST_OFF: begin
                    if (ph_zero) begin
                        state_nx  = ST_ON;
                        ph_load   = 1'b1;
                        ph_val    = on_q - ONE;
                        new_burst = 1'b1;
                        idx_inc   = 1'b1;
                    end else begin
                        ph_dec = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_nx = ST_IDLE;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so trigger
    // leaves a flop with no logic between it and the gated clock.
    always_comb begin
        trigger_d = (state_nx == ST_ON);
        busy_d    = (state_nx == ST_DELAY) || (state_nx == ST_ON) || (state_nx == ST_OFF);
        done_d    = (state_nx == ST_DONE);
        mark_d    = new_burst;
        idx_d     = burst_idx;
        if (accept) begin
            idx_d = ZERO;
        end else if (idx_inc) begin
            idx_d = burst_idx + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trigger    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            burst_mark <= 1'b0;
            burst_idx  <= ZERO;
            on_q       <= ZERO;
            off_q      <= ZERO;
        end else begin
            trigger    <= trigger_d;
            busy       <= busy_d;
            done       <= done_d;
            burst_mark <= mark_d;
            burst_idx  <= idx_d;
            if (accept) begin
                on_q  <= cfg_on;
                off_q <= cfg_off;
            end
        end
    end

endmodule

// File: tb/tb_transient_burst_ctrl.sv
// tb/tb_transient_burst_ctrl.sv - directed vector bench for transient_burst_ctrl
module tb_transient_burst_ctrl;

    typedef struct {
        int          d;
        int          n;
        int          f;
        int          b;
        int          done_cyc;
        logic [31:0] trig_mask;
        logic [31:0] mark_mask;
        int          trig_cnt;
        int          mark_cnt;
        int          busy_cnt;
        int          last_idx;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_delay = '0, cfg_on = '0, cfg_off = '0, cfg_bursts = '0;
    logic        trigger, busy, done, burst_mark;
    logic [15:0] burst_idx;

    logic        start4 = 1'b0;
    logic [3:0]  cfg4_delay = '0, cfg4_on = '0, cfg4_off = '0, cfg4_bursts = '0;
    logic        trigger4, busy4, done4, burst_mark4;
    logic [3:0]  burst_idx4;

    int n_vec = 0;
    int n_bad = 0;

    vec_t vt[8];
    vec_t v4;

    always #5 clk = ~clk;

    transient_burst_ctrl #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_delay  (cfg_delay),
        .cfg_on     (cfg_on),
        .cfg_off    (cfg_off),
        .cfg_bursts (cfg_bursts),
        .trigger    (trigger),
        .busy       (busy),
        .done       (done),
        .burst_mark (burst_mark),
        .burst_idx  (burst_idx)
    );

    transient_burst_ctrl #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .abort      (abort),
        .cfg_delay  (cfg4_delay),
        .cfg_on     (cfg4_on),
        .cfg_off    (cfg4_off),
        .cfg_bursts (cfg4_bursts),
        .trigger    (trigger4),
        .busy       (busy4),
        .done       (done4),
        .burst_mark (burst_mark4),
        .burst_idx  (burst_idx4)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Start accepted at the next rising edge (edge 0); cycle c is the
    // interval after edge c-1 and is sampled on the falling edge.
    task automatic run(input string nm, input vec_t v, input bit sel, input int pert);
        logic [31:0] tm, mm;
        int          dc, tc, mc, bc, dn;
        logic        t, m, b, dd;
        logic [15:0] idx;
        tm = '0; mm = '0; dc = -1; tc = 0; mc = 0; bc = 0; dn = 0; idx = '0;
        cfg_delay  = 16'(v.d);  cfg_on  = 16'(v.n);  cfg_off  = 16'(v.f);  cfg_bursts  = 16'(v.b);
        cfg4_delay = 4'(v.d);   cfg4_on = 4'(v.n);   cfg4_off = 4'(v.f);   cfg4_bursts = 4'(v.b);
        if (sel) start4 = 1'b1;
        else     start  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= v.done_cyc + 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start  = 1'b0;
                start4 = 1'b0;
            end
            t   = sel ? trigger4    : trigger;
            m   = sel ? burst_mark4 : burst_mark;
            b   = sel ? busy4       : busy;
            dd  = sel ? done4       : done;
            idx = sel ? {12'd0, burst_idx4} : burst_idx;
            if (t) tc++;
            if (m) mc++;
            if (b) bc++;
            if (c < 32) begin
                tm[c] = t;
                mm[c] = m;
            end
            if (dd) begin
                dn++;
                if (dc < 0) dc = c;
            end
            if (c == pert) begin
                cfg_delay = 16'd0; cfg_on = 16'd1; cfg_off = 16'd0; cfg_bursts = 16'd9;
                start = 1'b1;
            end else if (c == pert + 1) begin
                start = 1'b0;
            end
        end
        chk({nm, " trig_mask"},  tm,  v.trig_mask);
        chk({nm, " mark_mask"},  mm,  v.mark_mask);
        chk({nm, " done_cycle"}, dc,  v.done_cyc);
        chk({nm, " done_pulses"}, dn, 1);
        chk({nm, " trig_cnt"},   tc,  v.trig_cnt);
        chk({nm, " mark_cnt"},   mc,  v.mark_cnt);
        chk({nm, " busy_cnt"},   bc,  v.busy_cnt);
        chk({nm, " burst_idx"},  idx, v.last_idx);
    endtask

    initial begin
        int hi_cnt;
        //         d   n  f  b  done  trig_mask      mark_mask      tc  mc  bc  idx
        vt[0] = '{ 2,  3, 2, 2, 11,   32'h0000_0738, 32'h0000_0108,  6,  2, 10, 1 };
        vt[1] = '{ 0,  4, 0, 3, 13,   32'h0000_1FFE, 32'h0000_0222, 12,  3, 12, 2 };
        vt[2] = '{ 3,  0, 1, 5,  1,   32'h0000_0000, 32'h0000_0000,  0,  0,  0, 0 };
        vt[3] = '{ 3,  5, 1, 0,  1,   32'h0000_0000, 32'h0000_0000,  0,  0,  0, 0 };
        vt[4] = '{ 1,  1, 1, 3,  7,   32'h0000_0054, 32'h0000_0054,  3,  3,  6, 2 };
        vt[5] = '{ 0,  1, 0, 1,  2,   32'h0000_0002, 32'h0000_0002,  1,  1,  1, 0 };
        vt[6] = '{ 0,  2, 3, 2,  8,   32'h0000_00C6, 32'h0000_0042,  4,  2,  7, 1 };
        vt[7] = '{20,  7, 5, 4, 64,   32'h0FE0_0000, 32'h0020_0000, 28,  4, 63, 3 };
        v4    = '{ 0, 15, 1, 15, 240, 32'hFFFE_FFFE, 32'h0002_0002, 225, 15, 239, 14 };

        // reset values
        repeat (3) @(negedge clk);
        chk("rst trigger",    trigger,    0);
        chk("rst busy",       busy,       0);
        chk("rst done",       done,       0);
        chk("rst burst_mark", burst_mark, 0);
        chk("rst burst_idx",  burst_idx,  0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run($sformatf("vec%0d", i), vt[i], 1'b0, 0);
        end

        // abort in the second ON cycle
        cfg_delay = 16'd0; cfg_on = 16'd10; cfg_off = 16'd0; cfg_bursts = 16'd1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("abort on1 trigger", trigger, 1);
        @(negedge clk);
        chk("abort on2 trigger", trigger, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort trigger", trigger, 0);
        chk("abort busy",    busy,    0);
        hi_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || trigger || busy) hi_cnt++;
        end
        chk("abort no_done", hi_cnt, 0);

        // start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        hi_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (done || trigger || busy || burst_mark) hi_cnt++;
            @(negedge clk);
        end
        chk("start_abort idle", hi_cnt, 0);

        // run after abort is normal
        run("post_abort", vt[5], 1'b0, 0);

        // config change and start pulse during ON leave the run unchanged
        run("cfg_change", vt[0], 1'b0, 4);

        // asynchronous reset in the middle of OFF (cycle 5 of vec4, idx=1)
        cfg_delay = 16'd1; cfg_on = 16'd1; cfg_off = 16'd1; cfg_bursts = 16'd3;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst busy",      busy,      1);
        chk("pre_rst burst_idx", burst_idx, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst trigger",   trigger,   0);
        chk("async_rst busy",      busy,      0);
        chk("async_rst burst_idx", burst_idx, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("post_rst", vt[0], 1'b0, 0);

        // 4-bit instance at maximum counts
        run("max4", v4, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
